// File: rtl/ysyx_22050078_ifu_pf.sv
// Prefetching instruction fetch unit.
// Owns the fetch PC and keeps at most one aligned 8-byte read outstanding on the
// memory port. Each response yields one {pc, inst} pair, which is buffered in a
// small FIFO in front of the decoder. A redirect flushes the FIFO and retargets
// fetch. A response to a request issued before the redirect is discarded.
module ysyx_22050078_ifu_pf #(
  parameter int                   CPU_WIDTH  = 64,
  parameter int                   INST_WIDTH = 32,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = CPU_WIDTH'(64'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_redirect_valid,
  input  logic [CPU_WIDTH-1:0]  i_redirect_pc,
  output logic                  o_req_valid,
  output logic [CPU_WIDTH-1:0]  o_req_addr,
  input  logic                  i_req_ready,
  input  logic                  i_resp_valid,
  input  logic [CPU_WIDTH-1:0]  i_resp_data,
  output logic                  o_valid,
  output logic [CPU_WIDTH-1:0]  o_pc,
  output logic [INST_WIDTH-1:0] o_inst,
  input  logic                  i_ready
);

  localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // DROP means a request is in flight whose data belongs to a pre-redirect PC.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t                state_reg, state_next;
  logic [CPU_WIDTH-1:0]  fetch_pc_reg, fetch_pc_next;
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [CPU_WIDTH-1:0]  pc_mem   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [FIFO_DEPTH];
  logic                  push, pop;
  logic [INST_WIDTH-1:0] resp_inst;

  // Pick the 32-bit half of the 8-byte beat addressed by the fetch PC.
  generate
    if (CPU_WIDTH >= 64) begin : g_sel64
      assign resp_inst = fetch_pc_reg[2] ? i_resp_data[63:32] : i_resp_data[31:0];
    end else begin : g_sel32
      assign resp_inst = i_resp_data[INST_WIDTH-1:0];
    end
  endgenerate

  // A redirect cancels both the push and the pop in its cycle.
  assign push = (state_reg == S_WAIT) && i_resp_valid && !i_redirect_valid;
  assign pop  = o_valid && i_ready && !i_redirect_valid;

  // Occupancy after this edge; a redirect empties the FIFO outright.
  always_comb begin
    count_next = count_reg;
    if (i_redirect_valid) begin
      count_next = '0;
    end else begin
      count_next = count_reg + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end
  end

  // Fetch sequencing and fetch-PC update; redirect has the final say.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    case (state_reg)
      S_IDLE: begin
        if (!i_redirect_valid && (count_reg < DEPTH_C)) state_next = S_REQ;
      end
      S_REQ: begin
        if (i_req_ready) state_next = i_redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (i_resp_valid) begin
          if (i_redirect_valid)          state_next = S_IDLE;
          else if (count_next < DEPTH_C) state_next = S_REQ;
          else                           state_next = S_IDLE;
        end else if (i_redirect_valid) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (i_resp_valid) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (push)             fetch_pc_next = fetch_pc_reg + CPU_WIDTH'(4);
    if (i_redirect_valid) fetch_pc_next = i_redirect_pc;
  end

  // Control state, fetch PC and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      fetch_pc_reg <= RESET_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      count_reg    <= count_next;
      if (i_redirect_valid) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care until the count says otherwise.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= fetch_pc_reg;
      inst_mem[wr_ptr_reg] <= resp_inst;
    end
  end

  // Request always carries the 8-byte-aligned current fetch PC.
  assign o_req_valid = (state_reg == S_REQ);
  assign o_req_addr  = {fetch_pc_reg[CPU_WIDTH-1:3], 3'b000};

  // Head entry is held in registers; outputs read as zero when nothing is queued.
  assign o_valid = (count_reg != '0);
  assign o_pc    = o_valid ? pc_mem[rd_ptr_reg]   : '0;
  assign o_inst  = o_valid ? inst_mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_ysyx_22050078_ifu_pf.sv
// Scoreboard bench for the prefetching fetch unit: a randomized memory/IDU/redirect
// driver predicts the delivered {pc, inst} stream, a monitor pops and compares.
module tb_ysyx_22050078_ifu_pf;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int          DEPTH    = 4;

  logic        clk;
  logic        rst;
  logic        i_redirect_valid;
  logic [63:0] i_redirect_pc;
  logic        o_req_valid;
  logic [63:0] o_req_addr;
  logic        i_req_ready;
  logic        i_resp_valid;
  logic [63:0] i_resp_data;
  logic        o_valid;
  logic [63:0] o_pc;
  logic [31:0] o_inst;
  logic        i_ready;

  ysyx_22050078_ifu_pf #(
    .CPU_WIDTH (64),
    .INST_WIDTH(32),
    .FIFO_DEPTH(DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc   (i_redirect_pc),
    .o_req_valid     (o_req_valid),
    .o_req_addr      (o_req_addr),
    .i_req_ready     (i_req_ready),
    .i_resp_valid    (i_resp_valid),
    .i_resp_data     (i_resp_data),
    .o_valid         (o_valid),
    .o_pc            (o_pc),
    .o_inst          (o_inst),
    .i_ready         (i_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // Stimulus knobs (percentages and response delay range).
  int          p_ready, p_req_ready, p_redir, min_delay, max_delay;
  logic        force_redir;
  logic [63:0] force_pc;

  // Reference model: the PC stream restarts at each redirect/reset target and
  // advances by 4 for every response that belongs to the current epoch.
  logic        pending;
  logic [63:0] pend_addr;
  int          pend_epoch, pend_delay, epoch;
  logic [63:0] model_pc;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [31:0] lo, hi;
    if (a == 64'h8000_0000) return 64'h0000_0013_0000_0093;
    lo = a[31:0] ^ a[63:32] ^ 32'h5A3C_E187;
    hi = {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    return {hi, lo};
  endfunction

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    logic [63:0] w;
    w = mem_word({pc[63:3], 3'b000});
    return pc[2] ? w[63:32] : w[31:0];
  endfunction

  function automatic logic [63:0] rand_pc();
    if ($urandom_range(0, 7) == 0) return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3)) * 4;
    return RESET_PC + 64'($urandom_range(0, 255)) * 4;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Decide inputs for the coming edge and advance the model accordingly.
  task automatic drive_cycle();
    logic        redir, rrdy, rdy, resp;
    logic [63:0] rpc, rdata;
    redir       = force_redir || ($urandom_range(0, 99) < p_redir);
    rpc         = force_redir ? force_pc : rand_pc();
    force_redir = 1'b0;
    rrdy        = ($urandom_range(0, 99) < p_req_ready);
    rdy         = ($urandom_range(0, 99) < p_ready);
    resp        = 1'b0;
    rdata       = {$urandom, $urandom};
    if (pending) begin
      if (pend_delay == 0) begin
        resp    = 1'b1;
        rdata   = mem_word(pend_addr);
        pending = 1'b0;
        if (pend_epoch == epoch && !redir) begin
          exp_q.push_back('{pc: model_pc, inst: inst_of(model_pc)});
          model_pc = model_pc + 64'd4;
        end
      end else begin
        pend_delay--;
      end
    end
    if (o_req_valid && rrdy) begin
      check("req_addr", o_req_addr, {model_pc[63:3], 3'b000});
      pending    = 1'b1;
      pend_addr  = o_req_addr;
      pend_epoch = epoch;
      pend_delay = $urandom_range(min_delay, max_delay);
    end
    if (redir) begin
      epoch++;
      model_pc = rpc;
      exp_q.delete();
    end
    i_redirect_valid = redir;
    i_redirect_pc    = rpc;
    i_req_ready      = rrdy;
    i_resp_valid     = resp;
    i_resp_data      = rdata;
    i_ready          = rdy;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      next_cycle();
      drive_cycle();
    end
  endtask

  task automatic clear_inputs();
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i_req_ready      = 1'b0;
    i_resp_valid     = 1'b0;
    i_resp_data      = '0;
    i_ready          = 1'b0;
  endtask

  task automatic model_reset();
    pending = 1'b0;
    epoch++;
    exp_q.delete();
    model_pc = RESET_PC;
  endtask

  // Two reset edges; returns #1 after the last one (cycle 0).
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Run until the head becomes valid, then check it against the given PC.
  task automatic expect_first(input string name, input logic [63:0] pc);
    bit found;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      next_cycle();
      if (o_valid) begin
        found = 1;
        break;
      end
      drive_cycle();
    end
    check({name, "_seen"}, 64'(found), 64'd1);
    check({name, "_pc"}, o_pc, pc);
    check({name, "_inst"}, 64'(o_inst), 64'(inst_of(pc)));
    drive_cycle();
  endtask

  // Monitor: pop the scoreboard on each accepted head and compare.
  initial begin : monitor
    exp_t e;
    bit   prev_redir;
    prev_redir = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_redir = 0;
      end else begin
        if (prev_redir) check("valid_after_redirect", 64'(o_valid), 64'd0);
        if (o_valid && i_ready && !i_redirect_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pop_unexpected: got pc=%h inst=%h, required no valid entry", o_pc, o_inst);
          end else begin
            e = exp_q.pop_front();
            $display("pop pc=%h inst=%h (expected pc=%h inst=%h)", o_pc, o_inst, e.pc, e.inst);
            check("pop_pc", o_pc, e.pc);
            check("pop_inst", 64'(o_inst), 64'(e.inst));
          end
        end
        prev_redir = i_redirect_valid;
      end
    end
  end

  initial begin : stim
    bit          found;
    logic [63:0] stale_addr;
    rst         = 1'b1;
    epoch       = 0;
    force_redir = 1'b0;
    force_pc    = '0;
    clear_inputs();

    // Latency with zero-wait memory.
    p_ready = 100; p_req_ready = 100; p_redir = 0; min_delay = 0; max_delay = 0;
    do_reset();
    check("rst_req_valid", 64'(o_req_valid), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_pc", o_pc, 64'd0);
    check("rst_inst", 64'(o_inst), 64'd0);
    drive_cycle();
    next_cycle();
    check("lat_req_c1", 64'(o_req_valid), 64'd1);
    check("lat_addr_c1", o_req_addr, RESET_PC);
    drive_cycle();
    next_cycle();
    check("lat_valid_c2", 64'(o_valid), 64'd0);
    drive_cycle();
    next_cycle();
    check("lat_valid_c3", 64'(o_valid), 64'd1);
    check("lat_pc_c3", o_pc, RESET_PC);
    check("lat_inst_c3", 64'(o_inst), 64'h93);
    drive_cycle();
    run(10);

    // Fill with the decoder stalled.
    p_ready = 0;
    do_reset();
    drive_cycle();
    run(25);
    check("full_req_valid", 64'(o_req_valid), 64'd0);
    check("full_valid", 64'(o_valid), 64'd1);
    check("full_head_pc", o_pc, RESET_PC);
    check("full_head_inst", 64'(o_inst), 64'h93);
    check("full_entries", 64'(exp_q.size()), 64'(DEPTH));
    next_cycle();
    p_ready = 100;
    drive_cycle();
    p_ready = 0;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      if (o_req_valid) begin
        found = 1;
        break;
      end
      drive_cycle();
    end
    check("refill_req_seen", 64'(found), 64'd1);
    check("refill_req_addr", o_req_addr, RESET_PC + 64'h10);
    drive_cycle();
    run(10);
    check("refill_single_req", 64'(o_req_valid), 64'd0);
    check("refill_entries", 64'(exp_q.size()), 64'(DEPTH));
    check("refill_head_pc", o_pc, RESET_PC + 64'h4);

    // Redirect while waiting with two entries queued.
    min_delay = 1; max_delay = 1;
    do_reset();
    drive_cycle();
    found = 0;
    for (int k = 0; k < 60; k++) begin
      next_cycle();
      if (pending && pend_delay > 0 && exp_q.size() == 2) begin
        found = 1;
        break;
      end
      drive_cycle();
    end
    check("wait_redir_setup", 64'(found), 64'd1);
    force_redir = 1'b1;
    force_pc    = 64'h8000_0100;
    drive_cycle();
    next_cycle();
    check("wait_redir_valid", 64'(o_valid), 64'd0);
    p_ready = 100;
    drive_cycle();
    expect_first("wait_redir_first", 64'h8000_0100);

    // Redirect while a request is held unaccepted.
    p_req_ready = 0;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      next_cycle();
      if (o_req_valid) begin
        found = 1;
        break;
      end
      drive_cycle();
    end
    check("req_redir_setup", 64'(found), 64'd1);
    force_redir = 1'b1;
    force_pc    = 64'h8000_0204;
    drive_cycle();
    next_cycle();
    check("req_redir_valid", 64'(o_req_valid), 64'd1);
    check("req_redir_addr", o_req_addr, 64'h8000_0200);
    p_req_ready = 100;
    drive_cycle();
    expect_first("req_redir_first", 64'h8000_0204);

    // Redirect, pop and response in one cycle.
    p_ready = 50; min_delay = 0; max_delay = 1;
    found = 0;
    for (int k = 0; k < 400; k++) begin
      next_cycle();
      if (o_valid && pending && pend_delay == 0) begin
        found = 1;
        break;
      end
      drive_cycle();
    end
    check("triple_setup", 64'(found), 64'd1);
    p_ready     = 100;
    force_redir = 1'b1;
    force_pc    = 64'h8000_0300;
    drive_cycle();
    next_cycle();
    check("triple_valid", 64'(o_valid), 64'd0);
    drive_cycle();
    expect_first("triple_first", 64'h8000_0300);

    // Reset in WAIT with the response arriving right after.
    min_delay = 2; max_delay = 2;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      next_cycle();
      if (pending && pend_delay > 0) begin
        found = 1;
        break;
      end
      drive_cycle();
    end
    check("rst_wait_setup", 64'(found), 64'd1);
    stale_addr = pend_addr;
    rst = 1'b1;
    clear_inputs();
    model_reset();
    next_cycle();
    rst          = 1'b0;
    i_resp_valid = 1'b1;
    i_resp_data  = mem_word(stale_addr);
    check("rst_wait_valid", 64'(o_valid), 64'd0);
    check("rst_wait_pc", o_pc, 64'd0);
    check("rst_wait_req", 64'(o_req_valid), 64'd0);
    next_cycle();
    check("rst_restart_req", 64'(o_req_valid), 64'd1);
    check("rst_restart_valid", 64'(o_valid), 64'd0);
    min_delay = 0; max_delay = 0;
    drive_cycle();
    expect_first("rst_restart_first", RESET_PC);

    // Random traffic with redirects, stalls and variable memory latency.
    p_ready = 70; p_req_ready = 60; p_redir = 4; min_delay = 0; max_delay = 3;
    run(3000);
    p_redir = 0; p_ready = 100;
    run(60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22050078_ifu_pf.md
Name: ysyx_22050078_ifu_pf

Overview:
- Next-generation instruction fetch unit. Instruction memory becomes an explicit request/response port instead of a combinational read triggered on every PC change.
- Owns the fetch PC. Issues one aligned fetch at a time and buffers fetched {pc, inst} pairs in a parametrised prefetch FIFO ahead of the IDU.
- Supports redirect (branch/jump dnpc) with flush and stale-response discard.
- Sits between the PCU/EXU redirect path, the memory port (DPI bridge in simulation) and the IDU.

Parameters:
- CPU_WIDTH, 64, address and memory data width.
- INST_WIDTH, 32, instruction width.
- FIFO_DEPTH, 4, prefetch FIFO entries. Power of two, ≥2.
- RESET_PC, 64'h8000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_redirect_valid  in  1  redirect request from PCU/EXU.
- i_redirect_pc  in  CPU_WIDTH  new fetch PC (dnpc); bits [1:0] are zero.
- o_req_valid  out  1  memory read request valid.
- o_req_addr  out  CPU_WIDTH  request address: fetch_pc with bits [2:0] cleared (8-byte aligned).
- i_req_ready  in  1  memory accepts request.
- i_resp_valid  in  1  read data valid.
- i_resp_data  in  CPU_WIDTH  8-byte read data.
- o_valid  out  1  FIFO head valid to IDU.
- o_pc  out  CPU_WIDTH  PC of head instruction (also used by difftest).
- o_inst  out  INST_WIDTH  head instruction.
- i_ready  in  1  IDU accepts head.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty (count=0, pointers 0).
  - o_req_valid=0, o_valid=0, o_pc=0, o_inst=0.
  - Reset mid-transaction abandons it. A response arriving in the first post-reset cycles while in IDLE is ignored.
- State machine: IDLE, REQ, WAIT, DROP.
  - IDLE → REQ when count + (state==WAIT ? 1 : 0) < FIFO_DEPTH and no redirect this cycle. One outstanding request maximum.
  - REQ: o_req_valid=1, o_req_addr from fetch_pc. On i_req_ready → WAIT.
  - WAIT:
    - i_resp_valid → push {fetch_pc, inst}, fetch_pc += 4.
    - Next state: REQ if space remains after push (back-to-back, no IDLE bubble), else IDLE.
  - DROP: i_resp_valid → discard data, go IDLE.
- Instruction select: inst = fetch_pc[2] ? i_resp_data[63:32] : i_resp_data[31:0]. For CPU_WIDTH=32, always [31:0].
- PC arithmetic: fetch_pc + 4 wraps modulo 2^CPU_WIDTH. No fault on wrap.
- Redirect (i_redirect_valid=1) has highest priority:
  - FIFO flushed at the edge: count=0. Any same-cycle push and pop are cancelled.
  - fetch_pc = i_redirect_pc.
  - State update:
    - WAIT with no resp this cycle → DROP.
    - WAIT with resp this cycle → resp discarded, → IDLE.
    - REQ accepted this cycle → DROP.
    - REQ not accepted → stay REQ. o_req_addr retargets to the new PC (the only permitted change of an unaccepted request).
    - DROP stays DROP (resp this cycle → IDLE).
    - IDLE stays IDLE.
  - o_valid=0 the cycle after a redirect.
- Output side:
  - o_valid = (count≠0). o_pc/o_inst are the registered head entry, stable while o_valid && !i_ready.
  - Pop on o_valid && i_ready && !i_redirect_valid.
  - Simultaneous push and pop at full or empty is legal; count is unchanged at full.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency, zero-wait memory (i_req_ready=1, resp the cycle after accept):
  - rst deasserted at edge 0 → o_req_valid at cycle 1.
  - Resp at cycle 2 → o_valid at cycle 3.
  - Steady throughput is one instruction per 2 cycles.
- Full: no request issued while count = FIFO_DEPTH, or count = FIFO_DEPTH−1 with a request outstanding. A response never overflows the FIFO.
- Responses in IDLE or REQ are protocol violations. The bench asserts they never occur.

Test Plan:
- Reset, zero-wait memory returning 64'h0000_0013_0000_0093 at 0x8000_0000, i_ready=1 → o_valid cycle 3 with o_pc=0x8000_0000, o_inst=0x00000093. Next: o_pc=0x8000_0004, o_inst=0x00000013.
- i_ready=0 held → exactly 4 entries buffered (PCs 0x8000_0000..0x8000_000C), o_req_valid stays 0. Head stable. After one pop, a single new request to 0x8000_0010 issues.
- Redirect to 0x8000_0100 while in WAIT with 2 entries queued → next cycle o_valid=0. Next response dropped. Next request addr 0x8000_0100. First delivered o_pc=0x8000_0100.
- Redirect to 0x8000_0204 with i_req_ready=0 in REQ → o_req_addr changes to 0x8000_0200 next cycle. Delivered inst is upper word, o_pc=0x8000_0204.
- Redirect, pop and response in the same cycle → FIFO empty, response discarded, no count underflow, state IDLE.
- rst asserted in WAIT, response arrives the following cycle → ignored. Fetch restarts at RESET_PC with o_valid=0 until the new response.
